// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and sizing helpers for the register-file writeback arbiter.
// The default widths here are the defaults of the top-level parameters.
package regfile_writeback_arbiter_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_REGS     = 16;
  localparam int DEF_SEL_WIDTH    = 4;
  localparam int DEF_B_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [DEF_SEL_WIDTH-1:0]  sel;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO buffering long-latency writeback requests.
// The head is only visible once an entry is stored; nothing falls through.
module regfile_wb_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_SEL_WIDTH + DEF_DATA_WIDTH,
  parameter int DEPTH     = DEF_B_FIFO_DEPTH,
  parameter int CNT_WIDTH = count_width(DEF_B_FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_reg;
  logic [PTR_WIDTH-1:0] rd_ptr_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 push_ok;
  logic                 pop_ok;

  assign push_ok   = push && (count_reg < CNT_WIDTH'(DEPTH));
  assign pop_ok    = pop && (count_reg != '0);
  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push_ok && !pop_ok)      count_reg <= count_reg + CNT_WIDTH'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges single-cycle (A) and buffered long-latency (B) writebacks onto the
// register-file write port, with a pending scoreboard driving operand stalls.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int NUM_REGS     = DEF_NUM_REGS,
  parameter  int SEL_WIDTH    = DEF_SEL_WIDTH,
  parameter  int B_FIFO_DEPTH = DEF_B_FIFO_DEPTH,
  localparam int CNT_WIDTH    = count_width(B_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_a_valid,
  input  logic [SEL_WIDTH-1:0]  in_a_sel,
  input  logic [DATA_WIDTH-1:0] in_a_data,
  input  logic                  in_b_valid,
  output logic                  out_b_ready,
  input  logic [SEL_WIDTH-1:0]  in_b_sel,
  input  logic [DATA_WIDTH-1:0] in_b_data,
  input  logic                  in_mark_en,
  input  logic [SEL_WIDTH-1:0]  in_mark_sel,
  input  logic [SEL_WIDTH-1:0]  in_read_sel_ra,
  input  logic [SEL_WIDTH-1:0]  in_read_sel_rb,
  input  logic [SEL_WIDTH-1:0]  in_read_sel_rc,
  output logic                  out_stall,
  output logic                  out_write_en,
  output logic [SEL_WIDTH-1:0]  out_write_sel,
  output logic [DATA_WIDTH-1:0] out_write_data,
  output logic [NUM_REGS-1:0]   out_pending,
  output logic [CNT_WIDTH-1:0]  out_b_count,
  output logic                  out_err
);

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                  b_push_req;
  req_t                  b_head;
  logic [CNT_WIDTH-1:0]  b_count;
  logic                  a_active;
  logic                  mark_active;
  logic                  b_push;
  logic                  b_pop;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;
  logic [NUM_REGS-1:0]   pending_reg;
  logic [NUM_REGS-1:0]   pending_next;
  logic                  err_reg;
  logic                  err_next;
  logic                  write_en_reg;
  logic                  write_en_next;
  logic [SEL_WIDTH-1:0]  write_sel_reg;
  logic [SEL_WIDTH-1:0]  write_sel_next;
  logic [DATA_WIDTH-1:0] write_data_reg;
  logic [DATA_WIDTH-1:0] write_data_next;

  assign a_active    = in_a_valid && (in_a_sel != '0);
  assign mark_active = in_mark_en && (in_mark_sel != '0);
  // Ready depends only on stored occupancy, so a full FIFO being popped stays not-ready.
  assign out_b_ready = (b_count < CNT_WIDTH'(B_FIFO_DEPTH));
  assign b_push      = in_b_valid && out_b_ready;
  assign b_pop       = !a_active && (b_count != '0);
  assign b_push_req  = '{sel: in_b_sel, data: in_b_data};

  regfile_wb_fifo #(
    .WIDTH     ($bits(req_t)),
    .DEPTH     (B_FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_b_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (b_push),
    .push_data (b_push_req),
    .pop       (b_pop),
    .head_data (b_head),
    .count     (b_count)
  );

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    assign set_vec[gi] = mark_active && (in_mark_sel == SEL_WIDTH'(gi));
    assign clr_vec[gi] = b_pop && (b_head.sel == SEL_WIDTH'(gi));
  end

  always_comb begin
    pending_next    = (pending_reg & ~clr_vec) | set_vec;
    pending_next[0] = 1'b0;
    err_next = err_reg
             || (mark_active && pending_reg[in_mark_sel] && !clr_vec[in_mark_sel])
             || (a_active && pending_reg[in_a_sel]);
  end

  always_comb begin
    write_en_next   = 1'b0;
    write_sel_next  = write_sel_reg;
    write_data_next = write_data_reg;
    if (a_active) begin
      write_en_next   = 1'b1;
      write_sel_next  = in_a_sel;
      write_data_next = in_a_data;
    end else if (b_pop && (b_head.sel != '0)) begin
      write_en_next   = 1'b1;
      write_sel_next  = b_head.sel;
      write_data_next = b_head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg    <= '0;
      err_reg        <= 1'b0;
      write_en_reg   <= 1'b0;
      write_sel_reg  <= '0;
      write_data_reg <= '0;
    end else begin
      pending_reg    <= pending_next;
      err_reg        <= err_next;
      write_en_reg   <= write_en_next;
      write_sel_reg  <= write_sel_next;
      write_data_reg <= write_data_next;
    end
  end

  // Register-file write-through covers the write cycle, so the stall can drop then.
  assign out_stall = pending_reg[in_read_sel_ra] | pending_reg[in_read_sel_rb]
                   | pending_reg[in_read_sel_rc];

  assign out_write_en   = write_en_reg;
  assign out_write_sel  = write_sel_reg;
  assign out_write_data = write_data_reg;
  assign out_pending    = pending_reg;
  assign out_b_count    = b_count;
  assign out_err        = err_reg;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed vector table, hand sequences
// and random traffic checked against a queue-based reference model.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_a_valid, in_b_valid, in_mark_en;
  logic [3:0]  in_a_sel, in_b_sel, in_mark_sel, ra, rb, rc;
  logic [31:0] in_a_data, in_b_data;
  logic        out_b_ready, out_stall, out_write_en, out_err;
  logic [3:0]  out_write_sel;
  logic [31:0] out_write_data;
  logic [15:0] out_pending;
  logic [1:0]  out_b_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_a_valid(in_a_valid), .in_a_sel(in_a_sel), .in_a_data(in_a_data),
    .in_b_valid(in_b_valid), .out_b_ready(out_b_ready),
    .in_b_sel(in_b_sel), .in_b_data(in_b_data),
    .in_mark_en(in_mark_en), .in_mark_sel(in_mark_sel),
    .in_read_sel_ra(ra), .in_read_sel_rb(rb), .in_read_sel_rc(rc),
    .out_stall(out_stall), .out_write_en(out_write_en),
    .out_write_sel(out_write_sel), .out_write_data(out_write_data),
    .out_pending(out_pending), .out_b_count(out_b_count), .out_err(out_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle();
    in_a_valid = 0; in_a_sel = 0; in_a_data = 0;
    in_b_valid = 0; in_b_sel = 0; in_b_data = 0;
    in_mark_en = 0; in_mark_sel = 0; ra = 0; rb = 0; rc = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] sel; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [15:0] m_pend;
  logic        m_err, m_en;
  logic [3:0]  m_sel;
  logic [31:0] m_data;

  task automatic model_reset();
    q.delete(); m_pend = 0; m_err = 0; m_en = 0; m_sel = 0; m_data = 0;
  endtask

  // Applies the current inputs for one clock and checks the DUT against the model.
  task automatic step(input string tag);
    logic a_act, mk_act, rdy, popped;
    logic [15:0] clr;
    ent_t e;
    #1;
    rdy = (q.size() < DEPTH);
    chk({tag, ".ready"}, out_b_ready, rdy);
    chk({tag, ".stall"}, out_stall, m_pend[ra] | m_pend[rb] | m_pend[rc]);
    a_act  = in_a_valid && in_a_sel != 0;
    mk_act = in_mark_en && in_mark_sel != 0;
    popped = !a_act && q.size() > 0;
    clr = 0;
    if (mk_act && m_pend[in_mark_sel] && !(popped && q[0].sel == in_mark_sel)) m_err = 1;
    if (a_act && m_pend[in_a_sel]) m_err = 1;
    if (a_act) begin
      m_en = 1; m_sel = in_a_sel; m_data = in_a_data;
    end else if (popped) begin
      e = q.pop_front();
      clr[e.sel] = 1'b1;
      m_en = (e.sel != 0);
      if (e.sel != 0) begin m_sel = e.sel; m_data = e.data; end
    end else begin
      m_en = 0;
    end
    m_pend = m_pend & ~clr;
    if (mk_act) m_pend[in_mark_sel] = 1'b1;
    m_pend[0] = 1'b0;
    if (in_b_valid && rdy) q.push_back('{sel: in_b_sel, data: in_b_data});
    @(posedge clk); #1;
    chk({tag, ".wen"}, out_write_en, m_en);
    if (m_en) begin
      chk({tag, ".wsel"}, out_write_sel, m_sel);
      chk({tag, ".wdata"}, out_write_data, m_data);
    end
    chk({tag, ".pending"}, out_pending, m_pend);
    chk({tag, ".count"}, out_b_count, q.size());
    chk({tag, ".err"}, out_err, m_err);
  endtask

  task automatic reset_mid_cycle(input string tag);
    #3 rst_n = 0;
    model_reset();
    #1;
    chk({tag, ".rst_wen"}, out_write_en, 1'b0);
    chk({tag, ".rst_ready"}, out_b_ready, 1'b1);
    chk({tag, ".rst_stall"}, out_stall, 1'b0);
    chk({tag, ".rst_pending"}, out_pending, 16'h0);
    chk({tag, ".rst_err"}, out_err, 1'b0);
    chk({tag, ".rst_count"}, out_b_count, 2'd0);
    @(negedge clk) rst_n = 1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic a_v; logic [3:0] a_sel; logic [31:0] a_data;
    logic b_v; logic [3:0] b_sel; logic [31:0] b_data;
    logic m_en; logic [3:0] m_sel; logic [3:0] ra;
    logic exp_stall; logic exp_en; logic [3:0] exp_sel; logic [31:0] exp_data;
    logic [15:0] exp_pend; logic exp_err;
  } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,  0, 1, 3, 32'hDEADBEEF, 16'h0000, 0};
    vecs[1] = '{0, 0, 0,            0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            16'h0000, 0};
    vecs[2] = '{0, 0, 0,            0, 0, 0, 1, 5, 0,  0, 0, 0, 0,            16'h0020, 0};
    vecs[3] = '{0, 0, 0,            1, 5, 32'h1234, 0, 0, 5, 1, 0, 0, 0,      16'h0020, 0};
    vecs[4] = '{0, 0, 0,            0, 0, 0, 0, 0, 5,  1, 1, 5, 32'h1234,     16'h0000, 0};
    vecs[5] = '{0, 0, 0,            0, 0, 0, 0, 0, 5,  0, 0, 0, 0,            16'h0000, 0};
    vecs[6] = '{0, 0, 0,            0, 0, 0, 1, 7, 0,  0, 0, 0, 0,            16'h0080, 0};
    vecs[7] = '{0, 0, 0,            1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0,        16'h0080, 0};
    vecs[8] = '{0, 0, 0,            0, 0, 0, 1, 7, 0,  0, 1, 7, 32'h77,       16'h0080, 0};
    vecs[9] = '{0, 0, 0,            0, 0, 0, 1, 7, 7,  1, 0, 0, 0,            16'h0080, 1};

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.wen", out_write_en, 1'b0);
    chk("reset.ready", out_b_ready, 1'b1);
    chk("reset.pending", out_pending, 16'h0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      in_a_valid = vecs[i].a_v; in_a_sel = vecs[i].a_sel; in_a_data = vecs[i].a_data;
      in_b_valid = vecs[i].b_v; in_b_sel = vecs[i].b_sel; in_b_data = vecs[i].b_data;
      in_mark_en = vecs[i].m_en; in_mark_sel = vecs[i].m_sel;
      ra = vecs[i].ra; rb = 0; rc = 0;
      #1;
      chk($sformatf("vec%0d.stall", i), out_stall, vecs[i].exp_stall);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.wen", i), out_write_en, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        chk($sformatf("vec%0d.wsel", i), out_write_sel, vecs[i].exp_sel);
        chk($sformatf("vec%0d.wdata", i), out_write_data, vecs[i].exp_data);
      end
      chk($sformatf("vec%0d.pending", i), out_pending, vecs[i].exp_pend);
      chk($sformatf("vec%0d.err", i), out_err, vecs[i].exp_err);
      $display("vec%0d: wen=%0b sel=%0d data=%08h pend=%04h err=%0b", i,
               out_write_en, out_write_sel, out_write_data, out_pending, out_err);
    end

    // Fill the FIFO with two entries behind A traffic, then reset mid-cycle.
    idle();
    in_a_valid = 1; in_a_sel = 1; in_a_data = 32'h11;
    in_b_valid = 1; in_b_sel = 2; in_b_data = 32'h22;
    repeat (2) @(posedge clk);
    #1 chk("fill.count", out_b_count, 2'd2);
    idle();
    ra = 7;
    reset_mid_cycle("midrst");
    ra = 0;
    for (int i = 0; i < 3; i++) step("drain_none");

    // Contention: A holds the port for 4 cycles while B offers 3 entries.
    begin
      int k = 0;
      for (int c = 0; c < 9; c++) begin
        logic acc;
        idle();
        if (c < 4) begin in_a_valid = 1; in_a_sel = 4'(c + 1); in_a_data = 32'hA000 + c; end
        if (k < 3) begin in_b_valid = 1; in_b_sel = 4'(8 + k); in_b_data = 32'hB000 + k; end
        acc = in_b_valid && (q.size() < DEPTH);
        step($sformatf("cont%0d", c));
        $display("cont%0d: wen=%0b sel=%0d data=%08h count=%0d", c,
                 out_write_en, out_write_sel, out_write_data, out_b_count);
        if (acc) k++;
      end
    end

    // r0 handling: marks, A writes and B entries to r0 must all be inert.
    idle();
    in_mark_en = 1; in_mark_sel = 0;
    in_a_valid = 1; in_a_sel = 0; in_a_data = 32'h55;
    in_b_valid = 1; in_b_sel = 0; in_b_data = 32'h66;
    step("r0_0");
    idle();
    step("r0_1");
    step("r0_2");

    // Random traffic with occasional mid-cycle resets.
    reset_mid_cycle("rrst0");
    for (int n = 0; n < 400; n++) begin
      in_a_valid  = ($urandom_range(99) < 40);
      in_a_sel    = 4'($urandom_range(15));
      in_a_data   = $urandom;
      in_b_valid  = ($urandom_range(99) < 50);
      in_b_sel    = 4'($urandom_range(15));
      in_b_data   = $urandom;
      in_mark_en  = ($urandom_range(99) < 30);
      in_mark_sel = 4'($urandom_range(15));
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 4'($urandom_range(15));
      step($sformatf("rnd%0d", n));
      if (n % 100 == 99) begin
        idle();
        reset_mid_cycle($sformatf("rrst%0d", n));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
